// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// The decoder and execute stage import these along with the unit.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [4:0]  ALUOP_MUL   = 5'b00110;
    localparam logic [4:0]  ALUOP_DIV   = 5'b00111;
    localparam int          ITERATIONS  = 32;
    localparam logic [31:0] RSTATUS_MUL = 32'd4;
    localparam logic [31:0] RSTATUS_DIV = 32'd5;

    // Two's-complement magnitude; 0x80000000 maps to 2^31 as an unsigned value.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        logic [31:0] r;
        if (v[31]) begin
            r = ~v + 32'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/multdiv_if.sv
// Start/operand/result bundle between the execute stage and the multiply/divide unit.
// The processor side drives starts and operands; the unit returns result and status.
interface multdiv_if #(
    parameter int WIDTH = 32
);
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_MULT,
        output ctrl_DIV,
        output data_operandA,
        output data_operandB,
        input  data_result,
        input  data_exception,
        input  data_resultRDY,
        input  busy
    );

    modport slave (
        input  ctrl_MULT,
        input  ctrl_DIV,
        input  data_operandA,
        input  data_operandB,
        output data_result,
        output data_exception,
        output data_resultRDY,
        output busy
    );
endinterface

// File: rtl/multdiv_div_nr_step.sv
// One non-restoring division step on magnitudes: shift {rem, quo} left, then
// add or subtract the divisor depending on the sign of the running remainder.
module div_nr_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_s,
    input  logic [WIDTH-1:0] quo_s,
    input  logic [WIDTH-1:0] dvsr_s,
    output logic [WIDTH:0]   rem_nxt_s,
    output logic [WIDTH-1:0] quo_nxt_s
);

    logic [WIDTH:0] shifted_s;

    // Shift, conditional add/sub, and new quotient bit from the result sign.
    always_comb begin
        shifted_s = {rem_s[WIDTH-1:0], quo_s[WIDTH-1]};
        if (rem_s[WIDTH]) begin
            rem_nxt_s = shifted_s + {1'b0, dvsr_s};
        end else begin
            rem_nxt_s = shifted_s - {1'b0, dvsr_s};
        end
        quo_nxt_s = {quo_s[WIDTH-2:0], ~rem_nxt_s[WIDTH]};
    end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply (radix-2 Booth) and divide (non-restoring) unit.
// Fixed 33-cycle start-to-ready latency; a new start while busy abandons the current op.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clock,
    input  logic        reset_n,
    multdiv_if.slave    bus
);

    state_e           state_r, state_nxt_s;
    logic [4:0]       cnt_r, cnt_nxt_s;
    // Multiplicand for MUL, |divisor| for DIV.
    logic [WIDTH-1:0] mcand_r, mcand_nxt_s;
    // Booth accumulator / division remainder; one guard bit so a 0x80000000
    // multiplicand cannot overflow the partial sum.
    logic [WIDTH:0]   acc_r, acc_nxt_s;
    logic [WIDTH-1:0] q_r, q_nxt_s;
    logic             qm1_r, qm1_nxt_s;
    logic             is_div_r, is_div_nxt_s;
    logic             sign_a_r, sign_a_nxt_s;
    logic             sign_b_r, sign_b_nxt_s;
    logic [WIDTH-1:0] result_r, result_nxt_s;
    logic             exception_r, exception_nxt_s;
    logic             rdy_r, rdy_nxt_s;
    logic             busy_r, busy_nxt_s;

    logic             start_mul_s, start_div_s;
    logic [WIDTH:0]   mcand_ext_s;
    logic [WIDTH:0]   booth_sum_s;
    logic [WIDTH:0]   div_rem_s;
    logic [WIDTH-1:0] div_quo_s;
    logic             last_iter_s;

    assign start_mul_s = bus.ctrl_MULT & ~bus.ctrl_DIV;
    assign start_div_s = bus.ctrl_DIV & ~bus.ctrl_MULT;
    assign mcand_ext_s = {mcand_r[WIDTH-1], mcand_r};
    assign last_iter_s = (cnt_r == 5'(ITERATIONS - 1));

    div_nr_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_s     (acc_r),
        .quo_s     (q_r),
        .dvsr_s    (mcand_r),
        .rem_nxt_s (div_rem_s),
        .quo_nxt_s (div_quo_s)
    );

    // Booth recoding of {Q[0], q-1}: add, subtract or pass the multiplicand.
    always_comb begin
        case ({q_r[0], qm1_r})
            2'b01:   booth_sum_s = acc_r + mcand_ext_s;
            2'b10:   booth_sum_s = acc_r - mcand_ext_s;
            default: booth_sum_s = acc_r;
        endcase
    end

    // Next-state and datapath update for the FSM.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        mcand_nxt_s     = mcand_r;
        acc_nxt_s       = acc_r;
        q_nxt_s         = q_r;
        qm1_nxt_s       = qm1_r;
        is_div_nxt_s    = is_div_r;
        sign_a_nxt_s    = sign_a_r;
        sign_b_nxt_s    = sign_b_r;
        result_nxt_s    = result_r;
        exception_nxt_s = exception_r;
        rdy_nxt_s       = 1'b0;
        busy_nxt_s      = busy_r;

        if (start_mul_s) begin
            state_nxt_s  = MUL;
            cnt_nxt_s    = 5'd0;
            mcand_nxt_s  = bus.data_operandA;
            acc_nxt_s    = {(WIDTH+1){1'b0}};
            q_nxt_s      = bus.data_operandB;
            qm1_nxt_s    = 1'b0;
            is_div_nxt_s = 1'b0;
            sign_a_nxt_s = 1'b0;
            sign_b_nxt_s = 1'b0;
            busy_nxt_s   = 1'b1;
        end else if (start_div_s) begin
            state_nxt_s  = DIV;
            cnt_nxt_s    = 5'd0;
            mcand_nxt_s  = abs32(bus.data_operandB);
            acc_nxt_s    = {(WIDTH+1){1'b0}};
            q_nxt_s      = abs32(bus.data_operandA);
            qm1_nxt_s    = 1'b0;
            is_div_nxt_s = 1'b1;
            sign_a_nxt_s = bus.data_operandA[WIDTH-1];
            sign_b_nxt_s = bus.data_operandB[WIDTH-1];
            busy_nxt_s   = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    busy_nxt_s = 1'b0;
                end
                MUL: begin
                    acc_nxt_s = {booth_sum_s[WIDTH], booth_sum_s[WIDTH:1]};
                    q_nxt_s   = {booth_sum_s[0], q_r[WIDTH-1:1]};
                    qm1_nxt_s = q_r[0];
                    cnt_nxt_s = cnt_r + 5'd1;
                    if (last_iter_s) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = MUL;
                    end
                end
                DIV: begin
                    acc_nxt_s = div_rem_s;
                    q_nxt_s   = div_quo_s;
                    cnt_nxt_s = cnt_r + 5'd1;
                    if (last_iter_s) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = DIV;
                    end
                end
                DONE: begin
                    state_nxt_s = IDLE;
                    rdy_nxt_s   = 1'b1;
                    busy_nxt_s  = 1'b1;
                    if (!is_div_r) begin
                        // Product overflows when the high word is not a sign extension.
                        result_nxt_s    = q_r;
                        exception_nxt_s = (acc_r[WIDTH-1:0] != {WIDTH{q_r[WIDTH-1]}});
                    end else if (mcand_r == {WIDTH{1'b0}}) begin
                        result_nxt_s    = {WIDTH{1'b0}};
                        exception_nxt_s = 1'b1;
                    end else if (sign_a_r ^ sign_b_r) begin
                        result_nxt_s    = ~q_r + {{(WIDTH-1){1'b0}}, 1'b1};
                        exception_nxt_s = 1'b0;
                    end else begin
                        // Same signs and a quotient of 2^31 only happens for 0x80000000 / -1.
                        result_nxt_s    = q_r;
                        exception_nxt_s = q_r[WIDTH-1];
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    busy_nxt_s  = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            cnt_r       <= 5'd0;
            mcand_r     <= {WIDTH{1'b0}};
            acc_r       <= {(WIDTH+1){1'b0}};
            q_r         <= {WIDTH{1'b0}};
            qm1_r       <= 1'b0;
            is_div_r    <= 1'b0;
            sign_a_r    <= 1'b0;
            sign_b_r    <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            exception_r <= 1'b0;
            rdy_r       <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            mcand_r     <= mcand_nxt_s;
            acc_r       <= acc_nxt_s;
            q_r         <= q_nxt_s;
            qm1_r       <= qm1_nxt_s;
            is_div_r    <= is_div_nxt_s;
            sign_a_r    <= sign_a_nxt_s;
            sign_b_r    <= sign_b_nxt_s;
            result_r    <= result_nxt_s;
            exception_r <= exception_nxt_s;
            rdy_r       <= rdy_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    assign bus.data_result    = result_r;
    assign bus.data_exception = exception_r;
    assign bus.data_resultRDY = rdy_r;
    assign bus.busy           = busy_r;

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed and random mul/div against a
// plain-arithmetic reference, plus abort, reset, dual-start and back-to-back cases.
module tb_multdiv_unit;
    import multdiv_pkg::*;

    logic clock = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    multdiv_if #(.WIDTH(32)) bus ();

    multdiv_unit #(.WIDTH(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference: signed arithmetic straight from the operation rules.
    function automatic void model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output bit exc);
        longint p;
        logic [63:0] pv;
        int q;
        if (!is_div) begin
            p   = longint'($signed(a)) * longint'($signed(b));
            pv  = p;
            res = pv[31:0];
            exc = (pv[63:32] != {32{pv[31]}});
        end else if (b == 32'd0) begin
            res = 32'd0;
            exc = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res = 32'h8000_0000;
            exc = 1'b1;
        end else begin
            q   = $signed(a) / $signed(b);
            res = q;
            exc = 1'b0;
        end
    endfunction

    function automatic logic [31:0] pick_operand();
        int sel;
        sel = $urandom_range(0, 7);
        case (sel)
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd1;
            4:       return 32'($urandom_range(0, 15)) - 32'd8;
            5:       return 32'($urandom_range(0, 65535));
            default: return $urandom;
        endcase
    endfunction

    // Present a one-cycle start (decoded from the ALU opcode) and scramble operands afterwards.
    task automatic start_op(input logic [4:0] aluop, input logic [31:0] a, input logic [31:0] b);
        bus.ctrl_MULT     = (aluop == ALUOP_MUL);
        bus.ctrl_DIV      = (aluop == ALUOP_DIV);
        bus.data_operandA = a;
        bus.data_operandB = b;
        tick();
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    // Cycles from just after the start edge until RDY is seen; -1 on timeout.
    task automatic wait_rdy(output int lat);
        int i;
        bit seen;
        lat  = -1;
        seen = 1'b0;
        i    = 0;
        while (!seen && i < 100) begin
            tick();
            i++;
            if (bus.data_resultRDY) begin
                seen = 1'b1;
                lat  = i;
            end
        end
    endtask

    task automatic test_reset();
        reset_n           = 1'b0;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = 32'd0;
        bus.data_operandB = 32'd0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        n_checks++;
        if (bus.data_result !== 32'd0) $display("FAIL reset_result: got %h want 0", bus.data_result);
        else n_pass++;
        n_checks++;
        if (bus.data_exception !== 1'b0) $display("FAIL reset_exc: got %b want 0", bus.data_exception);
        else n_pass++;
        n_checks++;
        if (bus.data_resultRDY !== 1'b0) $display("FAIL reset_rdy: got %b want 0", bus.data_resultRDY);
        else n_pass++;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy);
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [4:0]  ops [5] = '{ALUOP_MUL, ALUOP_MUL, ALUOP_DIV, ALUOP_DIV, ALUOP_DIV};
        logic [31:0] as  [5] = '{32'd7, 32'h0001_0000, 32'hFFFF_FFF9, 32'd5, 32'h8000_0000};
        logic [31:0] bs  [5] = '{32'hFFFF_FFFD, 32'h0001_0000, 32'd2, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] exp_res;
        bit          exp_exc;
        int          lat;
        for (int k = 0; k < 5; k++) begin
            model(ops[k] == ALUOP_DIV, as[k], bs[k], exp_res, exp_exc);
            start_op(ops[k], as[k], bs[k]);
            n_checks++;
            if (bus.busy !== 1'b1) $display("FAIL dir_busy[%0d]: got %b want 1", k, bus.busy);
            else n_pass++;
            wait_rdy(lat);
            n_checks++;
            if (lat !== 33) $display("FAIL dir_latency[%0d]: got %0d want 33", k, lat);
            else n_pass++;
            n_checks++;
            if (bus.data_result !== exp_res)
                $display("FAIL dir_result[%0d]: a=%h b=%h got %h want %h", k, as[k], bs[k], bus.data_result, exp_res);
            else n_pass++;
            n_checks++;
            if (bus.data_exception !== exp_exc)
                $display("FAIL dir_exc[%0d]: got %b want %b", k, bus.data_exception, exp_exc);
            else n_pass++;
            n_checks++;
            if (bus.busy !== 1'b1) $display("FAIL dir_busy_at_rdy[%0d]: got %b want 1", k, bus.busy);
            else n_pass++;
            tick();
            n_checks++;
            if (bus.data_resultRDY !== 1'b0 || bus.busy !== 1'b0)
                $display("FAIL dir_after_rdy[%0d]: got rdy=%b busy=%b want 0 0", k, bus.data_resultRDY, bus.busy);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, exp_res;
        bit          is_div, exp_exc;
        int          lat;
        for (int k = 0; k < 40; k++) begin
            is_div = $urandom_range(0, 1);
            a      = pick_operand();
            b      = pick_operand();
            model(is_div, a, b, exp_res, exp_exc);
            start_op(is_div ? ALUOP_DIV : ALUOP_MUL, a, b);
            wait_rdy(lat);
            n_checks++;
            if (lat !== 33) $display("FAIL rnd_latency[%0d]: got %0d want 33", k, lat);
            else n_pass++;
            n_checks++;
            if (bus.data_result !== exp_res || bus.data_exception !== exp_exc)
                $display("FAIL rnd_op[%0d]: div=%b a=%h b=%h got %h/%b want %h/%b",
                         k, is_div, a, b, bus.data_result, bus.data_exception, exp_res, exp_exc);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_abort();
        int lat;
        int early;
        early = 0;
        start_op(ALUOP_DIV, 32'd100, 32'd7);
        for (int i = 0; i < 9; i++) begin
            tick();
            if (bus.data_resultRDY) early++;
        end
        start_op(ALUOP_MUL, 32'd6, 32'd7);
        wait_rdy(lat);
        n_checks++;
        if (early !== 0) $display("FAIL abort_early_rdy: got %0d pulses want 0", early);
        else n_pass++;
        n_checks++;
        if (lat !== 33) $display("FAIL abort_latency: got %0d want 33", lat);
        else n_pass++;
        n_checks++;
        if (bus.data_result !== 32'd42 || bus.data_exception !== 1'b0)
            $display("FAIL abort_result: got %h/%b want 0000002a/0", bus.data_result, bus.data_exception);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        int bad;
        bad = 0;
        start_op(ALUOP_MUL, 32'd3, 32'd5);
        for (int i = 0; i < 19; i++) tick();
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.data_resultRDY !== 1'b0)
            $display("FAIL midreset_flags: got busy=%b rdy=%b want 0 0", bus.busy, bus.data_resultRDY);
        else n_pass++;
        n_checks++;
        if (bus.data_result !== 32'd0 || bus.data_exception !== 1'b0)
            $display("FAIL midreset_result: got %h/%b want 0/0", bus.data_result, bus.data_exception);
        else n_pass++;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.busy || bus.data_resultRDY) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL midreset_idle: got %0d active cycles want 0", bad);
        else n_pass++;
    endtask

    task automatic test_both_pulses();
        int bad;
        bad = 0;
        bus.ctrl_MULT     = 1'b1;
        bus.ctrl_DIV      = 1'b1;
        bus.data_operandA = 32'd9;
        bus.data_operandB = 32'd3;
        tick();
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL both_busy: got %b want 0", bus.busy);
        else n_pass++;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.busy || bus.data_resultRDY) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL both_idle: got %0d active cycles want 0", bad);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2, r1, r2;
        bit          e1, e2;
        int          lat;
        a1 = $urandom; b1 = 32'($urandom_range(1, 1000));
        a2 = pick_operand(); b2 = pick_operand();
        model(1'b1, a1, b1, r1, e1);
        model(1'b0, a2, b2, r2, e2);
        start_op(ALUOP_DIV, a1, b1);
        wait_rdy(lat);
        n_checks++;
        if (lat !== 33 || bus.data_result !== r1 || bus.data_exception !== e1)
            $display("FAIL b2b_first: got lat=%0d %h/%b want 33 %h/%b", lat, bus.data_result, bus.data_exception, r1, e1);
        else n_pass++;
        start_op(ALUOP_MUL, a2, b2);
        n_checks++;
        if (bus.busy !== 1'b1 || bus.data_resultRDY !== 1'b0)
            $display("FAIL b2b_restart: got busy=%b rdy=%b want 1 0", bus.busy, bus.data_resultRDY);
        else n_pass++;
        n_checks++;
        if (bus.data_result !== r1) $display("FAIL b2b_hold_during: got %h want %h", bus.data_result, r1);
        else n_pass++;
        wait_rdy(lat);
        n_checks++;
        if (lat !== 33 || bus.data_result !== r2 || bus.data_exception !== e2)
            $display("FAIL b2b_second: got lat=%0d %h/%b want 33 %h/%b", lat, bus.data_result, bus.data_exception, r2, e2);
        else n_pass++;
        for (int i = 0; i < 3; i++) tick();
        n_checks++;
        if (bus.data_result !== r2 || bus.data_exception !== e2 || bus.data_resultRDY !== 1'b0)
            $display("FAIL b2b_hold_after: got %h/%b rdy=%b want %h/%b 0",
                     bus.data_result, bus.data_exception, bus.data_resultRDY, r2, e2);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_abort();
        test_reset_mid();
        test_both_pulses();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
